// File: rtl/aes_round_ctrl_if.sv
// Handshake and datapath-control bundle between the AES round controller
// and its block source, result sink and datapath.
interface aes_round_ctrl_if;
    logic       in_valid;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic       load_en;
    logic       round_en;
    logic       final_en;
    logic       key_en;
    logic       busy;
    logic [3:0] round;

    modport master (
        output in_valid, out_ready,
        input  in_ready, out_valid, load_en, round_en, final_en, key_en, busy, round
    );

    modport slave (
        input  in_valid, out_ready,
        output in_ready, out_valid, load_en, round_en, final_en, key_en, busy, round
    );
endinterface

// File: rtl/aes_round_ctrl.sv
// AES round sequencer: INIT (key whitening), NUM_ROUNDS-1 full rounds, final round, DONE.
// Define AES_ROUND_CTRL_ABORT_EN to add an abort input that cancels a run in progress.
module aes_round_ctrl #(
    parameter int NUM_ROUNDS = 10
) (
    input logic clk,
    input logic arst,
`ifdef AES_ROUND_CTRL_ABORT_EN
    input logic abort,
`endif
    aes_round_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, INIT, ROUND, FINAL, DONE} state_t;

    localparam logic [3:0] LAST      = 4'(NUM_ROUNDS);
    localparam logic [3:0] LAST_FULL = 4'(NUM_ROUNDS - 1);

    state_t     state, nxt;
    logic [3:0] round_q, nxt_round;
    logic       abort_i;

`ifdef AES_ROUND_CTRL_ABORT_EN
    assign abort_i = abort;
`else
    assign abort_i = 1'b0;
`endif

    always_comb begin
        nxt       = state;
        nxt_round = round_q;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    nxt       = INIT;
                    nxt_round = 4'd0;
                end
            end
            INIT: begin
                if (abort_i) begin
                    nxt       = IDLE;
                    nxt_round = 4'd0;
                end else begin
                    nxt       = ROUND;
                    nxt_round = 4'd1;
                end
            end
            ROUND: begin
                if (abort_i) begin
                    nxt       = IDLE;
                    nxt_round = 4'd0;
                end else if (round_q >= LAST_FULL) begin
                    nxt       = FINAL;
                    nxt_round = LAST;
                end else begin
                    nxt_round = round_q + 4'd1;
                end
            end
            FINAL: begin
                if (abort_i) begin
                    nxt       = IDLE;
                    nxt_round = 4'd0;
                end else begin
                    nxt = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    nxt       = IDLE;
                    nxt_round = 4'd0;
                end
            end
            default: begin
                nxt       = IDLE;
                nxt_round = 4'd0;
            end
        endcase
    end

    // Outputs are registered from the next state so they reflect the state they sit in.
    always_ff @(posedge clk) begin
        if (!arst) begin
            state         <= IDLE;
            round_q       <= 4'd0;
            bus.in_ready  <= 1'b1;
            bus.busy      <= 1'b0;
            bus.load_en   <= 1'b0;
            bus.round_en  <= 1'b0;
            bus.final_en  <= 1'b0;
            bus.key_en    <= 1'b0;
            bus.out_valid <= 1'b0;
        end else begin
            state         <= nxt;
            round_q       <= nxt_round;
            bus.in_ready  <= (nxt == IDLE);
            bus.busy      <= (nxt != IDLE);
            bus.load_en   <= (nxt == INIT);
            bus.round_en  <= (nxt == ROUND);
            bus.final_en  <= (nxt == FINAL);
            bus.key_en    <= (nxt == ROUND) || (nxt == FINAL);
            bus.out_valid <= (nxt == DONE);
        end
    end

    assign bus.round = round_q;
endmodule

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 Parameter NUM_ROUNDS, default 10, number of cipher rounds; legal range 2..15.
REQ-002 clk  input  1  rising-edge clock; sole clock domain.
REQ-003 arst  input  1  reset, synchronous, active-low; sampled only on clk rising edge.
REQ-004 in_valid  input  1  block plus key present at datapath inputs.
REQ-005 in_ready  output  1  controller able to accept a block.
REQ-006 out_ready  input  1  downstream able to take the result.
REQ-007 out_valid  output  1  datapath state register holds the finished ciphertext.
REQ-008 load_en  output  1  datapath loads plaintext XOR cipher key (round 0).
REQ-009 round_en  output  1  datapath performs a full round (SubBytes, ShiftRows, MixColumns, AddRoundKey).
REQ-010 final_en  output  1  datapath performs the final round (no MixColumns).
REQ-011 key_en  output  1  key expander advances to the next round key.
REQ-012 round  output  4  current round index, 0..NUM_ROUNDS.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, INIT, ROUND, FINAL, DONE, held in a registered state vector.
REQ-015 in_ready SHALL be high only in IDLE; accept = in_valid && in_ready at a rising edge.
REQ-016 On accept at edge T: INIT during cycle T+1 (load_en=1, round=0).
REQ-017 ROUND SHALL span cycles T+2..T+NUM_ROUNDS with round_en=1, key_en=1, round incrementing 1..NUM_ROUNDS-1, one per cycle.
REQ-018 FINAL SHALL occupy cycle T+NUM_ROUNDS+1 with final_en=1, key_en=1, round=NUM_ROUNDS.
REQ-019 DONE SHALL begin at cycle T+NUM_ROUNDS+2 with out_valid=1; round holds NUM_ROUNDS; all enables 0.
REQ-020 out_valid SHALL stay high and round stable until out_valid && out_ready at an edge; next state IDLE, round returns to 0.
REQ-021 load_en, round_en, final_en SHALL be mutually exclusive and each decoded from the registered state only (no input-to-output combinational path).
REQ-022 in_valid SHALL be ignored outside IDLE; a request held during a run SHALL be accepted in the first IDLE cycle.
REQ-023 out_ready outside DONE SHALL have no effect.
REQ-024 round SHALL never exceed NUM_ROUNDS nor wrap; it returns to 0 only via IDLE.
REQ-025 Minimum accept-to-accept spacing SHALL be NUM_ROUNDS+3 cycles (out_ready held high).

Reset
REQ-026 With arst low at a rising edge: state=IDLE, round=0 next cycle, overriding every other input.
REQ-027 Reset values: in_ready=1 (IDLE), out_valid=0, load_en=0, round_en=0, final_en=0, key_en=0, busy=0, round=0.
REQ-028 Reset asserted mid-run (any state) SHALL discard the operation; no out_valid follows.

Configuration
REQ-029 Macro AES_ROUND_CTRL_ABORT_EN defined: extra input port abort (1 bit); abort high at an edge in INIT, ROUND or FINAL forces IDLE, round=0 next cycle, no out_valid; abort ignored in IDLE and DONE.
REQ-030 Macro undefined: port abort absent; behaviour identical to defined build with abort tied low.

Verification
REQ-031 Reset then single block, NUM_ROUNDS=10, out_ready=1: accept at T -> load_en @T+1, round_en @T+2..T+10 (round 1..9), final_en @T+11 (round 10), out_valid @T+12, in_ready @T+13.
REQ-032 Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid and round=10 held 6 cycles, IDLE after handshake.
REQ-033 in_valid held constantly high, out_ready=1 -> accepts exactly every 13 cycles; no enable overlap.
REQ-034 arst low at round=5 -> next cycle round=0, busy=0, all enables 0; out_valid never asserted.
REQ-035 AES_ROUND_CTRL_ABORT_EN defined, abort pulsed in FINAL -> IDLE next cycle, no out_valid; abort pulsed in DONE -> out_valid unaffected.
REQ-036 NUM_ROUNDS=2 -> INIT, one ROUND (round=1), FINAL (round=2), DONE at T+4.
